// File: rtl/spi_slave_sync.sv
// SPI slave (cs active-low, LSB first) sampled entirely in the clk domain; optional miso return under SPI_SLV_MISO_EN.
// Latency: SYNC_STAGES+1 clk from a pin edge to action; done/frame_err pulse one clk after the deciding edge.
// Backpressure: none; words arrive at the master's pace and dout simply holds until the next full word.
module spi_slave_sync #(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  done,
    output logic                  frame_err
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {IDLE, RECV, FULL} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
    logic [SYNC_STAGES:0]    flush_pipe;
    logic                    s_sclk, s_cs, s_mosi, s_sclk_d, s_cs_d;
    logic                    rise, fall, cs_rise, cs_fall, armed;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    start, sample, last, err, shift_tx, in_frame;

    assign s_sclk = sclk_sync[SYNC_STAGES-1];
    assign s_cs   = cs_sync[SYNC_STAGES-1];
    assign s_mosi = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            s_sclk_d   <= 1'b0;
            s_cs_d     <= 1'b1;
            flush_pipe <= '0;
            armed      <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            s_sclk_d   <= s_sclk;
            s_cs_d     <= s_cs;
            flush_pipe <= {flush_pipe[SYNC_STAGES-1:0], 1'b1};
            // A frame already running at reset release must not look like a fresh cs_fall:
            // only arm once the flushed synchronizer has really seen cs high.
            armed      <= armed | (flush_pipe[SYNC_STAGES] & s_cs);
        end
    end

    assign rise    =  s_sclk & ~s_sclk_d;
    assign fall    = ~s_sclk &  s_sclk_d;
    assign cs_rise =  s_cs   & ~s_cs_d;
    assign cs_fall = ~s_cs   &  s_cs_d & armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        sample    = 1'b0;
        last      = 1'b0;
        err       = 1'b0;
        shift_tx  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    start     = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                // cs_rise outranks a coincident fall: the partial bit is dropped.
                if (cs_rise) begin
                    err       = (bit_cnt != '0);
                    state_nxt = IDLE;
                end else begin
                    if (fall && bit_cnt <= LAST_BIT) begin
                        sample = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            last      = 1'b1;
                            state_nxt = FULL;
                        end
                    end
                    if (rise && bit_cnt != '0 && bit_cnt <= LAST_BIT) shift_tx = 1'b1;
                end
            end
            FULL: begin
                if (cs_rise) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift     <= '0;
            dout      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done      <= last;
            frame_err <= err;
            if (start) begin
                bit_cnt <= '0;
                shift   <= '0;
            end else if (sample) begin
                shift   <= {s_mosi, shift[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + ONE;
            end
            if (last) dout <= {s_mosi, shift[DATA_WIDTH-1:1]};
        end
    end

    assign in_frame = (state == RECV) && (state_nxt == RECV);

`ifdef SPI_SLV_MISO_EN
    logic [DATA_WIDTH-1:0] tx_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift <= '0;
            miso     <= 1'b0;
        end else if (start) begin
            tx_shift <= tx_data;
            miso     <= tx_data[0];
        end else if (!in_frame) begin
            miso <= 1'b0;
        end else if (shift_tx) begin
            miso <= tx_shift[bit_cnt];
        end
    end
`else
    logic unused_tx;

    assign unused_tx = ^{tx_data, shift_tx, in_frame};
    assign miso      = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: table of frames plus back-to-back and mid-frame reset sequences.
module tb_spi_slave_sync;
    localparam int DW = 12;
`ifdef SPI_SLV_MISO_EN
    localparam bit MISO_ON = 1'b1;
`else
    localparam bit MISO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sclk = 1'b0;
    logic          cs = 1'b1;
    logic          mosi = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso;
    logic [DW-1:0] dout;
    logic          done;
    logic          frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [DW-1:0] done_log[$];

    spi_slave_sync #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
        .tx_data(tx_data), .miso(miso), .dout(dout), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_log.push_back(dout);
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    typedef struct {
        logic [15:0]   word;
        int            nbits;
        logic [DW-1:0] tx;
        int            exp_done;
        int            exp_err;
        logic [DW-1:0] exp_dout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk cycle, 6 clk per phase; mosi changes on rise, miso captured as the master would at fall.
    task automatic sclk_bit(input logic b, output logic m);
        sclk = 1'b1;
        mosi = b;
        wait_clks(6);
        m = miso;
        sclk = 1'b0;
        wait_clks(6);
    endtask

    task automatic run_frame(input logic [15:0] w, input int n, output logic [15:0] cap);
        logic m;
        cap = '0;
        cs = 1'b0;
        wait_clks(6);
        for (int i = 0; i < n; i++) begin
            sclk_bit(w[i], m);
            cap[i] = m;
        end
        cs = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        logic [15:0] cap, cap2;
        logic        m;
        int          d0, e0;

        vecs[0] = '{16'h0A5C,  12, 12'h9B6, 1, 0, 12'hA5C};
        vecs[1] = '{16'h0001,  12, 12'h9B6, 1, 0, 12'h001};
        vecs[2] = '{16'h0FFF,  12, 12'h9B6, 1, 0, 12'hFFF};
        vecs[3] = '{16'h03C3,   5, 12'h9B6, 0, 1, 12'hFFF};
        vecs[4] = '{16'hC5A5,  14, 12'h9B6, 1, 0, 12'h5A5};
        vecs[5] = '{16'h0000,   0, 12'h9B6, 0, 0, 12'h5A5};

        wait_clks(3);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_miso", 32'(miso), 32'h0);
        reset = 1'b0;
        wait_clks(10);

        for (int v = 0; v < 6; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            tx_data = vecs[v].tx;
            run_frame(vecs[v].word, vecs[v].nbits, cap);
            wait_clks(12);
            chk($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
            chk($sformatf("vec%0d_err", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_dout", v), 32'(dout), 32'(vecs[v].exp_dout));
            chk($sformatf("vec%0d_miso_idle", v), 32'(miso), 32'h0);
            if (vecs[v].nbits >= DW)
                chk($sformatf("vec%0d_miso_word", v), 32'(cap[DW-1:0]),
                    MISO_ON ? 32'(vecs[v].tx) : 32'h0);
        end

        // Back-to-back: cs high for a single clk between frames.
        d0 = done_cnt;
        tx_data = 12'h3A7;
        run_frame(16'h0001, 12, cap);
        wait_clks(1);
        run_frame(16'h0FFF, 12, cap2);
        wait_clks(12);
        chk("b2b_done", 32'(done_cnt - d0), 32'd2);
        if (done_log.size() >= 2) begin
            chk("b2b_first", 32'(done_log[done_log.size()-2]), 32'h001);
            chk("b2b_second", 32'(done_log[done_log.size()-1]), 32'hFFF);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL b2b_log: got %0d done words, expected at least 2", done_log.size());
        end
        chk("b2b_miso2", 32'(cap2[DW-1:0]), MISO_ON ? 32'h3A7 : 32'h0);

        // Reset mid-frame, released with cs still low: the rest of that frame is ignored.
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data = 12'h9B6;
        cs = 1'b0;
        wait_clks(6);
        for (int i = 0; i < 5; i++) sclk_bit(1'b1, m);
        sclk = 1'b1;
        mosi = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("mid_reset_dout", 32'(dout), 32'h0);
        chk("mid_reset_done", 32'(done), 32'h0);
        chk("mid_reset_frame_err", 32'(frame_err), 32'h0);
        chk("mid_reset_miso", 32'(miso), 32'h0);
        wait_clks(3);
        reset = 1'b0;
        wait_clks(6);
        sclk = 1'b0;
        wait_clks(6);
        for (int i = 0; i < 7; i++) sclk_bit(1'b1, m);
        cs = 1'b1;
        wait_clks(12);
        chk("post_reset_no_done", 32'(done_cnt - d0), 32'd0);
        chk("post_reset_no_err", 32'(err_cnt - e0), 32'd0);
        chk("post_reset_dout", 32'(dout), 32'h0);

        d0 = done_cnt;
        run_frame(16'h0A5C, 12, cap);
        wait_clks(12);
        chk("recover_done", 32'(done_cnt - d0), 32'd1);
        chk("recover_dout", 32'(dout), 32'hA5C);
        chk("recover_miso", 32'(cap[DW-1:0]), MISO_ON ? 32'h9B6 : 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
